mc_controller: RTL and testbench

Multi-cycle MIPS control unit. It replaces the single-cycle combinational controller with a state machine that sequences fetch, decode, execute, memory and writeback over shared datapath resources. It adds a memory ready handshake with timeout, illegal-instruction fault, and a retired-instruction counter. It sits between the instruction register/memory interface and the multi-cycle datapath muxes.

---
 rtl/mc_controller_pkg.sv | 69 ++++++
 rtl/mc_decode.sv | 38 +++
 rtl/mc_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_mc_controller.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// rtl/mc_controller_pkg.sv - shared state, opcode, function and mux select codes for the multi-cycle controller
package mc_defs;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] A_PC = 2'b00;
    localparam logic [1:0] A_RS = 2'b01;
    localparam logic [1:0] A_RT = 2'b10;

    localparam logic [1:0] B_RT    = 2'b00;
    localparam logic [1:0] B_FOUR  = 2'b01;
    localparam logic [1:0] B_IMM   = 2'b10;
    localparam logic [1:0] B_IMMSH = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [2:0] M2R_ALUOUT = 3'b000;
    localparam logic [2:0] M2R_MDR    = 3'b001;
    localparam logic [2:0] M2R_PC     = 3'b010;

    // Bit positions of the one-hot instruction class vector.
    localparam int NCLASS  = 11;
    localparam int CL_ADDU = 0;
    localparam int CL_SUBU = 1;
    localparam int CL_SLL  = 2;
    localparam int CL_JR   = 3;
    localparam int CL_ORI  = 4;
    localparam int CL_LUI  = 5;
    localparam int CL_LW   = 6;
    localparam int CL_SW   = 7;
    localparam int CL_BEQ  = 8;
    localparam int CL_J    = 9;
    localparam int CL_JAL  = 10;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational op/funct to one-hot instruction class decoder
//   op, funct  : instruction register fields
//   instrClass : one-hot class, all zero when unsupported
//   legal      : set when op/funct is a supported instruction
module mc_decode
    import mc_defs::*;
(
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    output logic [NCLASS-1:0] instrClass,
    output logic              legal
);

    always_comb begin
        instrClass = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: instrClass[CL_ADDU] = 1'b1;
                    FN_SUBU: instrClass[CL_SUBU] = 1'b1;
                    FN_SLL:  instrClass[CL_SLL]  = 1'b1;
                    FN_JR:   instrClass[CL_JR]   = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  instrClass[CL_ORI] = 1'b1;
            OP_LUI:  instrClass[CL_LUI] = 1'b1;
            OP_LW:   instrClass[CL_LW]  = 1'b1;
            OP_SW:   instrClass[CL_SW]  = 1'b1;
            OP_BEQ:  instrClass[CL_BEQ] = 1'b1;
            OP_J:    instrClass[CL_J]   = 1'b1;
            OP_JAL:  instrClass[CL_JAL] = 1'b1;
            default: ;
        endcase
        legal = |instrClass;
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control FSM with memory wait timeout, fault and retire counter
//   clk, reset         : clock, synchronous active-high reset
//   op, funct, zero    : IR fields and ALU zero flag
//   mem_ready          : memory completes the current access this cycle
//   pcWrite..aluControl: datapath enables and mux selects
//   state              : current FSM state code
//   instr_done, retired: retirement pulse and wrapping retire count
//   fault              : sticky illegal-instruction / timeout flag
module mc_controller
    import mc_defs::*;
#(
    parameter int CNT_W       = 32,
    parameter int WAIT_W      = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcWrite,
    output logic [1:0]       pcSrc,
    output logic             iorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             regWrite,
    output logic [1:0]       regDst,
    output logic [2:0]       memtoReg,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic             extOp,
    output logic [2:0]       aluControl,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             fault
);

    localparam bit               TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             curState;
    state_t             nextState;
    logic [NCLASS-1:0]  cls;
    logic               legal;
    logic               isRAlu;
    logic               retireNow;
    logic               timeoutHit;
    logic [WAIT_W-1:0]  waitCnt;
    logic [CNT_W-1:0]   retiredCnt;

    mc_decode uDecode (
        .op         (op),
        .funct      (funct),
        .instrClass (cls),
        .legal      (legal)
    );

    assign isRAlu     = cls[CL_ADDU] | cls[CL_SUBU] | cls[CL_SLL];
    // A ready in the last allowed cycle still completes normally.
    assign timeoutHit = TIMEOUT_EN && !mem_ready && (waitCnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            curState <= S_FETCH;
        end else begin
            curState <= nextState;
        end
    end

    always_comb begin
        nextState = curState;
        retireNow = 1'b0;
        case (curState)
            S_FETCH: begin
                if (mem_ready) begin
                    nextState = S_DECODE;
                end else if (timeoutHit) begin
                    nextState = S_FAULT;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    nextState = S_FAULT;
                end else if (cls[CL_J] | cls[CL_JAL]) begin
                    nextState = S_FETCH;
                    retireNow = 1'b1;
                end else begin
                    nextState = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls[CL_BEQ] | cls[CL_JR]) begin
                    nextState = S_FETCH;
                    retireNow = 1'b1;
                end else if (cls[CL_LW] | cls[CL_SW]) begin
                    nextState = S_MEM;
                end else begin
                    nextState = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cls[CL_LW]) begin
                        nextState = S_WB;
                    end else begin
                        nextState = S_FETCH;
                        retireNow = 1'b1;
                    end
                end else if (timeoutHit) begin
                    nextState = S_FAULT;
                end
            end
            S_WB: begin
                nextState = S_FETCH;
                retireNow = 1'b1;
            end
            S_FAULT: nextState = S_FAULT;
            default: nextState = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt    <= '0;
            retiredCnt <= '0;
        end else begin
            if (nextState != curState) begin
                waitCnt <= '0;
            end else if ((curState == S_FETCH || curState == S_MEM) && !mem_ready) begin
                waitCnt <= waitCnt + WAIT_W'(1);
            end
            if (retireNow) begin
                retiredCnt <= retiredCnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        pcWrite    = 1'b0;
        pcSrc      = PC_ALU;
        iorD       = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regWrite   = 1'b0;
        regDst     = RD_RT;
        memtoReg   = M2R_ALUOUT;
        aluSrcA    = A_PC;
        aluSrcB    = B_RT;
        extOp      = 1'b0;
        aluControl = ALU_ADD;
        case (curState)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = B_FOUR;
                if (mem_ready) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                end
            end
            S_DECODE: begin
                // Branch target is computed here speculatively into ALUOut.
                aluSrcB = B_IMMSH;
                extOp   = 1'b1;
                if (cls[CL_J] | cls[CL_JAL]) begin
                    pcWrite = 1'b1;
                    pcSrc   = PC_JUMP;
                end
                if (cls[CL_JAL]) begin
                    regWrite = 1'b1;
                    regDst   = RD_RA;
                    memtoReg = M2R_PC;
                end
            end
            S_EXEC: begin
                if (isRAlu) begin
                    aluSrcA    = cls[CL_SLL] ? A_RT : A_RS;
                    aluControl = cls[CL_SLL] ? ALU_SLL : (cls[CL_SUBU] ? ALU_SUB : ALU_ADD);
                end
                if (cls[CL_ORI]) begin
                    aluSrcA    = A_RS;
                    aluSrcB    = B_IMM;
                    aluControl = ALU_OR;
                end
                if (cls[CL_LUI]) begin
                    aluSrcB    = B_IMM;
                    aluControl = ALU_LUI;
                end
                if (cls[CL_LW] | cls[CL_SW]) begin
                    aluSrcA = A_RS;
                    aluSrcB = B_IMM;
                    extOp   = 1'b1;
                end
                if (cls[CL_BEQ]) begin
                    aluSrcA    = A_RS;
                    aluControl = ALU_SUB;
                    pcWrite    = zero;
                    pcSrc      = PC_ALUOUT;
                end
                if (cls[CL_JR]) begin
                    pcWrite = 1'b1;
                    pcSrc   = PC_RS;
                end
            end
            S_MEM: begin
                iorD     = 1'b1;
                memRead  = cls[CL_LW];
                memWrite = cls[CL_SW];
            end
            S_WB: begin
                regWrite = 1'b1;
                regDst   = isRAlu ? RD_RD : RD_RT;
                memtoReg = cls[CL_LW] ? M2R_MDR : M2R_ALUOUT;
            end
            default: ;
        endcase
        // Nothing may be written while reset is asserted, whatever state we are in.
        if (reset) begin
            pcWrite  = 1'b0;
            irWrite  = 1'b0;
            regWrite = 1'b0;
            memRead  = 1'b0;
            memWrite = 1'b0;
        end
    end

    assign state      = curState;
    assign fault      = (curState == S_FAULT);
    assign instr_done = retireNow & ~reset;
    assign retired    = retiredCnt;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized scoreboard bench for mc_controller
module tb_mc_controller;

    localparam int CW = 4;
    localparam int TO = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic [5:0]    op        = '0;
    logic [5:0]    funct     = '0;
    logic          zero      = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pcWrite;
    logic [1:0]    pcSrc;
    logic          iorD;
    logic          memRead;
    logic          memWrite;
    logic          irWrite;
    logic          regWrite;
    logic [1:0]    regDst;
    logic [2:0]    memtoReg;
    logic [1:0]    aluSrcA;
    logic [1:0]    aluSrcB;
    logic          extOp;
    logic [2:0]    aluControl;
    logic [2:0]    state;
    logic          instr_done;
    logic [CW-1:0] retired;
    logic          fault;

    always #5 clk = ~clk;

    mc_controller #(.CNT_W(CW), .WAIT_W(8), .MEM_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcWrite    (pcWrite),
        .pcSrc      (pcSrc),
        .iorD       (iorD),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .regWrite   (regWrite),
        .regDst     (regDst),
        .memtoReg   (memtoReg),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .extOp      (extOp),
        .aluControl (aluControl),
        .state      (state),
        .instr_done (instr_done),
        .retired    (retired),
        .fault      (fault)
    );

    typedef enum int {I_ADDU, I_SUBU, I_SLL, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL} ins_e;

    typedef struct packed {
        logic [2:0]    st;
        logic          pcWrite;
        logic [1:0]    pcSrc;
        logic          iorD;
        logic          memRead;
        logic          memWrite;
        logic          irWrite;
        logic          regWrite;
        logic [1:0]    regDst;
        logic [2:0]    memtoReg;
        logic [1:0]    aluSrcA;
        logic [1:0]    aluSrcB;
        logic          extOp;
        logic [2:0]    aluControl;
        logic          instrDone;
        logic          fault;
        logic [CW-1:0] retired;
    } obs_t;

    obs_t  expQ[$];
    string tagQ[$];
    int    nChecks = 0;
    int    nFails  = 0;
    int    modelRetired = 0;

    function automatic logic [5:0] opOf(input ins_e i);
        case (i)
            I_ORI:   return 6'h0d;
            I_LUI:   return 6'h0f;
            I_LW:    return 6'h23;
            I_SW:    return 6'h2b;
            I_BEQ:   return 6'h04;
            I_J:     return 6'h02;
            I_JAL:   return 6'h03;
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [5:0] fnOf(input ins_e i);
        case (i)
            I_ADDU:  return 6'h21;
            I_SUBU:  return 6'h23;
            I_SLL:   return 6'h00;
            I_JR:    return 6'h08;
            default: return 6'h3f;
        endcase
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.st      = st;
        e.fault   = (st == 3'd7);
        e.retired = CW'(modelRetired % (1 << CW));
        return e;
    endfunction

    function automatic obs_t sampleDut();
        obs_t a;
        a.st         = state;
        a.pcWrite    = pcWrite;
        a.pcSrc      = pcSrc;
        a.iorD       = iorD;
        a.memRead    = memRead;
        a.memWrite   = memWrite;
        a.irWrite    = irWrite;
        a.regWrite   = regWrite;
        a.regDst     = regDst;
        a.memtoReg   = memtoReg;
        a.aluSrcA    = aluSrcA;
        a.aluSrcB    = aluSrcB;
        a.extOp      = extOp;
        a.aluControl = aluControl;
        a.instrDone  = instr_done;
        a.fault      = fault;
        a.retired    = retired;
        return a;
    endfunction

    // Monitor: every sampled cycle with a pending expectation is compared.
    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        string t;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            a = sampleDut();
            nChecks++;
            if (a !== e) begin
                nFails++;
                $display("FAIL %s: got %h expected %h (state got %0d exp %0d)", t, a, e, a.st, e.st);
            end
        end
    end

    task automatic cyc(input obs_t e, input string tag, input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        expQ.push_back(e);
        tagQ.push_back(tag);
        @(posedge clk);
        #1;
        if (e.instrDone) modelRetired++;
    endtask

    task automatic doReset(input int n);
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            nChecks++;
            if ({pcWrite, irWrite, regWrite, memRead, memWrite, instr_done} !== 6'b0) begin
                nFails++;
                $display("FAIL reset_enables: got %b expected 000000",
                         {pcWrite, irWrite, regWrite, memRead, memWrite, instr_done});
            end
            @(posedge clk);
            #1;
        end
        reset        = 1'b0;
        modelRetired = 0;
    endtask

    // waits cycles without mem_ready, then optionally one completing cycle.
    task automatic fetchPhase(input int waits, input bit completes);
        obs_t e;
        for (int k = 0; k <= waits; k++) begin
            if (k == waits && !completes) break;
            op    = 6'($urandom);
            funct = 6'($urandom);
            e = base(3'd0);
            e.memRead = 1'b1;
            e.aluSrcB = 2'b01;
            if (k == waits) begin
                e.irWrite = 1'b1;
                e.pcWrite = 1'b1;
            end
            cyc(e, "fetch", k == waits, 1'($urandom));
        end
    endtask

    task automatic faultCycles(input int n, input string tag);
        obs_t e;
        for (int k = 0; k < n; k++) begin
            op = 6'($urandom);
            e  = base(3'd7);
            cyc(e, tag, 1'($urandom), 1'($urandom));
        end
    endtask

    // hang: memory never answers in MEM, expecting a timeout fault.
    task automatic runInstr(input ins_e ins, input int fw, input int mw, input logic z, input bit hang);
        obs_t e;
        bit   rtype;
        rtype = (ins == I_ADDU || ins == I_SUBU || ins == I_SLL);
        fetchPhase(fw, 1'b1);
        op    = opOf(ins);
        funct = (opOf(ins) == 6'h00) ? fnOf(ins) : 6'($urandom);

        e = base(3'd1);
        e.aluSrcB = 2'b11;
        e.extOp   = 1'b1;
        if (ins == I_J || ins == I_JAL) begin
            e.pcWrite   = 1'b1;
            e.pcSrc     = 2'b10;
            e.instrDone = 1'b1;
        end
        if (ins == I_JAL) begin
            e.regWrite = 1'b1;
            e.regDst   = 2'b10;
            e.memtoReg = 3'b010;
        end
        cyc(e, {ins.name(), "_decode"}, 1'($urandom), 1'($urandom));
        if (ins == I_J || ins == I_JAL) return;

        e = base(3'd2);
        case (ins)
            I_ADDU: e.aluSrcA = 2'b01;
            I_SUBU: begin e.aluSrcA = 2'b01; e.aluControl = 3'b001; end
            I_SLL:  begin e.aluSrcA = 2'b10; e.aluControl = 3'b011; end
            I_ORI:  begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.aluControl = 3'b010; end
            I_LUI:  begin e.aluSrcB = 2'b10; e.aluControl = 3'b100; end
            I_LW, I_SW: begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.extOp = 1'b1; end
            I_BEQ:  begin
                e.aluSrcA = 2'b01; e.aluControl = 3'b001;
                e.pcWrite = z; e.pcSrc = 2'b01; e.instrDone = 1'b1;
            end
            I_JR:   begin e.pcWrite = 1'b1; e.pcSrc = 2'b11; e.instrDone = 1'b1; end
            default: ;
        endcase
        cyc(e, {ins.name(), "_exec"}, 1'($urandom), (ins == I_BEQ) ? z : 1'($urandom));
        if (ins == I_BEQ || ins == I_JR) return;

        if (ins == I_LW || ins == I_SW) begin
            for (int k = 0; k <= (hang ? TO - 1 : mw); k++) begin
                bit rdy;
                rdy = !hang && (k == mw);
                e = base(3'd3);
                e.iorD     = 1'b1;
                e.memRead  = (ins == I_LW);
                e.memWrite = (ins == I_SW);
                e.instrDone = rdy && (ins == I_SW);
                cyc(e, {ins.name(), "_mem"}, rdy, 1'($urandom));
            end
            if (hang) begin
                faultCycles(5, "mem_timeout_fault");
                return;
            end
            if (ins == I_SW) return;
        end

        e = base(3'd4);
        e.regWrite  = 1'b1;
        e.regDst    = rtype ? 2'b01 : 2'b00;
        e.memtoReg  = (ins == I_LW) ? 3'b001 : 3'b000;
        e.instrDone = 1'b1;
        cyc(e, {ins.name(), "_wb"}, 1'($urandom), 1'($urandom));
    endtask

    task automatic runIllegal(input logic [5:0] o, input logic [5:0] f);
        obs_t e;
        fetchPhase(0, 1'b1);
        op    = o;
        funct = f;
        e = base(3'd1);
        e.aluSrcB = 2'b11;
        e.extOp   = 1'b1;
        cyc(e, "illegal_decode", 1'($urandom), 1'($urandom));
        faultCycles(20, "fault_hold");
    endtask

    task automatic runRandom(input int n);
        for (int i = 0; i < n; i++) begin
            runInstr(ins_e'($urandom_range(0, 10)), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom), 1'b0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] badFn;
        doReset(3);

        runInstr(I_ADDU, 0, 0, 1'b0, 1'b0);
        runInstr(I_LW,   0, 3, 1'b0, 1'b0);
        runInstr(I_BEQ,  0, 0, 1'b0, 1'b0);
        runInstr(I_BEQ,  0, 0, 1'b1, 1'b0);
        runInstr(I_JAL,  0, 0, 1'b0, 1'b0);
        runRandom(12);
        nChecks++;
        if (retired !== CW'(17 % (1 << CW))) begin
            nFails++;
            $display("FAIL retired_wrap: got %0d expected %0d", retired, 17 % (1 << CW));
        end

        runRandom(60);

        runIllegal(6'h3f, 6'($urandom));
        doReset(2);
        runInstr(I_SW, 1, 2, 1'b0, 1'b0);

        fetchPhase(TO, 1'b0);
        faultCycles(5, "fetch_timeout_fault");
        doReset(1);

        // Reset arriving in DECODE of a jal must suppress its writes.
        fetchPhase(0, 1'b1);
        op = opOf(I_JAL);
        doReset(2);
        runInstr(I_J, 0, 0, 1'b0, 1'b0);

        runInstr(I_LW, 0, 0, 1'b0, 1'b1);
        doReset(1);

        do badFn = 6'($urandom); while (badFn inside {6'h21, 6'h23, 6'h00, 6'h08});
        runIllegal(6'h00, badFn);
        doReset(1);
        runInstr(I_ORI, 0, 0, 1'b0, 1'b0);
        runRandom(10);

        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
